// File: rtl/mood_pkg.sv
// Shared mood codes, handshake states and the one-hot mood encoder used by
// the sprite sequencer and other consumers of the pet FSM status bus.
package mood_pkg;

    localparam int MOOD_W = 4;
    localparam int N_MOOD = 9;

    typedef enum logic [MOOD_W-1:0] {
        MOOD_IDLE    = 4'd0,
        MOOD_NEUTRAL = 4'd1,
        MOOD_TIRED   = 4'd2,
        MOOD_SLEEP   = 4'd3,
        MOOD_HUNGRY  = 4'd4,
        MOOD_SAD     = 4'd5,
        MOOD_PLAYING = 4'd6,
        MOOD_BORED   = 4'd7,
        MOOD_DEATH   = 4'd8
    } mood_e;

    typedef enum logic {
        H_IDLE = 1'b0,
        H_REQ  = 1'b1
    } hs_state_e;

    // Returns {exactly_one_bit_set, index_of_set_bit}.
    function automatic logic [MOOD_W:0] onehot_encode(input logic [N_MOOD-1:0] s);
        int                cnt;
        logic [MOOD_W-1:0] code;
        cnt  = 0;
        code = '0;
        for (int i = 0; i < N_MOOD; i++) begin
            if (s[i]) begin
                cnt  = cnt + 1;
                code = MOOD_W'(i);
            end
        end
        return {(cnt == 1), code};
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running 1 ms tick generator: one-cycle tick every TICK_DIV clocks,
// with a synchronous clear so callers can restart the millisecond phase.
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mood_sprite_sequencer.sv
// Turns the control FSM's one-hot mood into a sprite code plus a per-mood
// frame animation, and hands each new (sprite, frame) pair to the display.
module mood_sprite_sequencer
    import mood_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int FRAME_MS = 250,
    parameter int FRAMES   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sign_IDLE,
    input  logic                      sign_NEUTRAL,
    input  logic                      sign_TIRED,
    input  logic                      sign_SLEEP,
    input  logic                      sign_HUNGRY,
    input  logic                      sign_SAD,
    input  logic                      sign_PLAYING,
    input  logic                      sign_BORED,
    input  logic                      sign_DEATH,
    input  logic                      frame_ack,
    output logic                      frame_req,
    output logic [MOOD_W-1:0]         sprite_id,
    output logic [$clog2(FRAMES)-1:0] frame_idx,
    output logic                      mood_changed,
    output logic                      mood_err
);

    localparam int               FW        = $clog2(FRAMES);
    localparam int               MS_W      = $clog2(2 * FRAME_MS);
    localparam logic [MS_W-1:0]  MS_LAST_N = MS_W'(FRAME_MS - 1);
    localparam logic [MS_W-1:0]  MS_LAST_S = MS_W'(2 * FRAME_MS - 1);

    logic [N_MOOD-1:0] sign_q, sign_d;
    logic              sign_vld_q, sign_vld_d;
    logic              boot_q, boot_d;
    mood_e             cur_mood_q, cur_mood_d;
    logic [FW-1:0]     cur_frame_q, cur_frame_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    hs_state_e         state_q, state_d;
    logic              pending_q, pending_d;
    logic [MOOD_W-1:0] sprite_q, sprite_d;
    logic [FW-1:0]     fidx_q, fidx_d;
    logic              mood_changed_q, mood_changed_d;

    logic [MOOD_W:0]   enc;
    logic              enc_ok;
    mood_e             enc_code;
    logic              mood_chg;
    logic              ms_tick;
    logic              frame_adv;
    logic              upd;
    logic [MS_W-1:0]   ms_last;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (mood_chg),
        .tick (ms_tick)
    );

    // sign_vld_q masks mood_err until the sign register holds real inputs.
    always_comb begin
        sign_d     = {sign_DEATH, sign_BORED, sign_PLAYING, sign_SAD, sign_HUNGRY,
                      sign_SLEEP, sign_TIRED, sign_NEUTRAL, sign_IDLE};
        sign_vld_d = 1'b1;
        boot_d     = 1'b0;
        enc        = onehot_encode(sign_q);
        enc_ok     = enc[MOOD_W];
        enc_code   = mood_e'(enc[MOOD_W-1:0]);
        mood_err   = sign_vld_q && !enc_ok;
        mood_chg   = enc_ok && (enc_code != cur_mood_q);
    end

    // Frame timer; a mood change restarts the animation with a full first frame.
    always_comb begin
        cur_mood_d     = cur_mood_q;
        cur_frame_d    = cur_frame_q;
        ms_d           = ms_q;
        frame_adv      = 1'b0;
        ms_last        = (cur_mood_q == MOOD_SLEEP) ? MS_LAST_S : MS_LAST_N;
        mood_changed_d = mood_chg;
        if (mood_chg) begin
            cur_mood_d  = enc_code;
            cur_frame_d = '0;
            ms_d        = '0;
        end else if ((cur_mood_q != MOOD_DEATH) && ms_tick) begin
            if (ms_q == ms_last) begin
                ms_d        = '0;
                frame_adv   = 1'b1;
                cur_frame_d = cur_frame_q + FW'(1);
            end else begin
                ms_d = ms_q + MS_W'(1);
            end
        end
    end

    // Handshake: events during a request coalesce into one pending re-request,
    // which always carries the newest mood/frame.
    always_comb begin
        upd       = boot_q || mood_chg || frame_adv;
        state_d   = state_q;
        pending_d = pending_q;
        sprite_d  = sprite_q;
        fidx_d    = fidx_q;
        case (state_q)
            H_IDLE: begin
                if (upd || pending_q) begin
                    sprite_d  = cur_mood_d;
                    fidx_d    = cur_frame_d;
                    pending_d = 1'b0;
                    state_d   = H_REQ;
                end
            end
            H_REQ: begin
                pending_d = pending_q || upd;
                if (frame_ack) begin
                    state_d = H_IDLE;
                end
            end
            default: state_d = H_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_q         <= '0;
            sign_vld_q     <= 1'b0;
            boot_q         <= 1'b1;
            cur_mood_q     <= MOOD_IDLE;
            cur_frame_q    <= '0;
            ms_q           <= '0;
            state_q        <= H_IDLE;
            pending_q      <= 1'b0;
            sprite_q       <= '0;
            fidx_q         <= '0;
            mood_changed_q <= 1'b0;
        end else begin
            sign_q         <= sign_d;
            sign_vld_q     <= sign_vld_d;
            boot_q         <= boot_d;
            cur_mood_q     <= cur_mood_d;
            cur_frame_q    <= cur_frame_d;
            ms_q           <= ms_d;
            state_q        <= state_d;
            pending_q      <= pending_d;
            sprite_q       <= sprite_d;
            fidx_q         <= fidx_d;
            mood_changed_q <= mood_changed_d;
        end
    end

    assign frame_req    = (state_q == H_REQ);
    assign sprite_id    = sprite_q;
    assign frame_idx    = fidx_q;
    assign mood_changed = mood_changed_q;

endmodule
